// File: rtl/seq_pulse_pkg.sv
// Shared state definitions for the multi-channel high-low-high-low sequence detector.
package seq_pulse_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        STOP  = 2'b10,
        CLEAR = 2'b11
    } state_t;

endpackage

// File: rtl/seq_pulse_fsm_if.sv
// Control inputs and per-channel status outputs of seq_pulse_fsm, bundled for port connection.
interface seq_pulse_fsm_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic                  en;
    logic                  mode;
    logic                  clr_cnt;
    logic [CH-1:0]         a;
    logic [CH-1:0]         k1;
    logic [CH-1:0]         k2;
    logic [CH-1:0]         tmo;
    logic [2*CH-1:0]       state;
    logic [CH*CNT_W-1:0]   seq_cnt;

    modport master (
        output en, mode, clr_cnt, a,
        input  k1, k2, tmo, state, seq_cnt
    );

    modport slave (
        input  en, mode, clr_cnt, a,
        output k1, k2, tmo, state, seq_cnt
    );

endinterface

// File: rtl/seq_pulse_ch.sv
// One channel: Idle/Start/Stop/Clear FSM with dwell timeout, pulse flags and saturating count.
module seq_pulse_ch
    import seq_pulse_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000,
    parameter int TMO_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             clr_cnt,
    input  logic             a,
    output logic             k1,
    output logic             k2,
    output logic             tmo,
    output state_t           state,
    output logic [CNT_W-1:0] seq_cnt
);

    localparam logic [TMO_W-1:0] DWELL_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] dwell;
    logic             go;

    // NOTE: always_comb with a default assigned first cannot infer a latch.
    always_comb begin
        go = 1'b0;
        case (state)
            IDLE:    go = a;
            START:   go = !a;
            STOP:    go = a;
            CLEAR:   go = !a;
            default: go = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dwell   <= '0;
            k1      <= 1'b0;
            k2      <= 1'b0;
            tmo     <= 1'b0;
            seq_cnt <= '0;
        end else begin
            k1  <= 1'b0;
            k2  <= 1'b0;
            tmo <= 1'b0;
            if (clr_cnt) seq_cnt <= '0;

            if (!en) begin
                state <= IDLE;
                dwell <= '0;
            end else if (go) begin
                dwell <= '0;
                case (state)
                    IDLE:  state <= START;
                    START: state <= STOP;
                    STOP: begin
                        state <= CLEAR;
                        k2    <= 1'b1;
                    end
                    CLEAR: begin
                        state <= mode ? STOP : IDLE;
                        k1    <= 1'b1;
                        // A same-cycle clear beats the increment.
                        if (!clr_cnt && seq_cnt != '1) seq_cnt <= seq_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                dwell <= '0;
            end else if (TIMEOUT != 0 && dwell == DWELL_LAST) begin
                state <= IDLE;
                dwell <= '0;
                tmo   <= 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_pulse_fsm.sv
// CH independent sequence-detector channels sharing enable, mode and counter clear.
module seq_pulse_fsm
    import seq_pulse_pkg::*;
#(
    parameter int CH      = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000,
    parameter int TMO_W   = 16
) (
    input logic           clk,
    input logic           rst,
    seq_pulse_fsm_if.slave bus
);

    logic [CH-1:0]       k1_w;
    logic [CH-1:0]       k2_w;
    logic [CH-1:0]       tmo_w;
    logic [2*CH-1:0]     state_w;
    logic [CH*CNT_W-1:0] cnt_w;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t st;

        seq_pulse_ch #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT),
            .TMO_W   (TMO_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .mode    (bus.mode),
            .clr_cnt (bus.clr_cnt),
            .a       (bus.a[i]),
            .k1      (k1_w[i]),
            .k2      (k2_w[i]),
            .tmo     (tmo_w[i]),
            .state   (st),
            .seq_cnt (cnt_w[i*CNT_W +: CNT_W])
        );

        assign state_w[STATE_W*i +: STATE_W] = st;
    end

    assign bus.k1      = k1_w;
    assign bus.k2      = k2_w;
    assign bus.tmo     = tmo_w;
    assign bus.state   = state_w;
    assign bus.seq_cnt = cnt_w;

endmodule

// File: tb/tb_seq_pulse_fsm.sv
// Directed bench for seq_pulse_fsm: CH=4, CNT_W=4, TIMEOUT=8, plus a TIMEOUT=0 single-channel copy.
module tb_seq_pulse_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_pulse_fsm_if #(.CH(4), .CNT_W(4)) bus0 ();
    seq_pulse_fsm_if #(.CH(1), .CNT_W(4)) bus1 ();

    seq_pulse_fsm #(.CH(4), .CNT_W(4), .TIMEOUT(8), .TMO_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seq_pulse_fsm #(.CH(1), .CNT_W(4), .TIMEOUT(0), .TMO_W(16)) u_dut_nt (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] av);
        bus0.a = av;
        @(posedge clk);
        #1;
    endtask

    int t1_a  [6] = '{1, 1, 0, 0, 1, 0};
    int t1_st [6] = '{1, 1, 2, 2, 3, 0};
    int t1_k2 [6] = '{0, 0, 0, 0, 1, 0};
    int t1_k1 [6] = '{0, 0, 0, 0, 0, 1};
    int k1n, k2n, idle_hits, tmo_hits, not_start;
    logic bit_v;

    initial begin
        bus0.en = 1'b0; bus0.mode = 1'b0; bus0.clr_cnt = 1'b0; bus0.a = '0;
        bus1.en = 1'b1; bus1.mode = 1'b0; bus1.clr_cnt = 1'b0; bus1.a = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus0.state), 32'h00);
        check("rst_pulses", {bus0.k1, bus0.k2, bus0.tmo}, 32'h0);
        check("rst_cnt", 32'(bus0.seq_cnt), 32'h0);
        rst = 1'b0;
        bus0.en = 1'b1;

        // 1: basic pattern on ch0
        for (int i = 0; i < 6; i++) begin
            cyc(4'(t1_a[i]));
            check($sformatf("t1_state_%0d", i), 32'(bus0.state), 32'(t1_st[i]));
            check($sformatf("t1_k2_%0d", i), 32'(bus0.k2), 32'(t1_k2[i]));
            check($sformatf("t1_k1_%0d", i), 32'(bus0.k1), 32'(t1_k1[i]));
        end
        check("t1_cnt", 32'(bus0.seq_cnt), 32'h0001);

        // 2: continuous mode on ch1
        bus0.mode = 1'b1;
        k1n = 0; k2n = 0; idle_hits = 0;
        for (int i = 0; i < 10; i++) begin
            bit_v = (i % 2 == 0);
            cyc({2'b00, bit_v, 1'b0});
            k1n += int'(bus0.k1[1]);
            k2n += int'(bus0.k2[1]);
            if (bus0.state[3:2] == 2'b00) idle_hits++;
        end
        check("t2_k1_count", 32'(k1n), 32'd4);
        check("t2_k2_count", 32'(k2n), 32'd4);
        check("t2_idle_hits", 32'(idle_hits), 32'd0);
        check("t2_cnt1", 32'(bus0.seq_cnt[7:4]), 32'd4);
        check("t2_state1", 32'(bus0.state[3:2]), 32'd2);
        bus0.mode = 1'b0;
        bus0.en = 1'b0;
        cyc(4'b0000);
        check("t2_en_off_state", 32'(bus0.state), 32'h00);
        bus0.en = 1'b1;

        // 3: dwell timeout on ch2
        cyc(4'b0100);
        check("t3_enter", 32'(bus0.state[5:4]), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc(4'b0100);
            check($sformatf("t3_hold_%0d", i), {bus0.tmo, 6'b0, bus0.state[5:4]}, 32'h1);
        end
        cyc(4'b0100);
        check("t3_tmo", 32'(bus0.tmo), 32'h4);
        check("t3_state", 32'(bus0.state[5:4]), 32'd0);
        check("t3_no_k", {bus0.k1, bus0.k2}, 32'h0);
        cyc(4'b0000);
        check("t3_tmo_width", 32'(bus0.tmo), 32'h0);

        // 3b: TIMEOUT=0 never aborts
        bus1.a = 1'b1;
        cyc(4'b0000);
        tmo_hits = 0; not_start = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(4'b0000);
            tmo_hits += int'(bus1.tmo[0]);
            if (bus1.state != 2'b01) not_start++;
        end
        check("t3b_tmo_hits", 32'(tmo_hits), 32'd0);
        check("t3b_not_start", 32'(not_start), 32'd0);
        bus1.a = 1'b0;

        // 4: saturation on ch3, then clear racing a completion
        for (int n = 1; n <= 17; n++) begin
            cyc(4'b1000); cyc(4'b0000); cyc(4'b1000); cyc(4'b0000);
            if (n == 15) check("t4_cnt_15", 32'(bus0.seq_cnt[15:12]), 32'd15);
        end
        check("t4_cnt_sat", 32'(bus0.seq_cnt[15:12]), 32'd15);
        cyc(4'b1000); cyc(4'b0000); cyc(4'b1000);
        bus0.clr_cnt = 1'b1;
        cyc(4'b0000);
        check("t4_clr_k1", 32'(bus0.k1), 32'h8);
        check("t4_clr_cnt", 32'(bus0.seq_cnt), 32'h0);
        bus0.clr_cnt = 1'b0;
        cyc(4'b0000);
        check("t4_k1_width", 32'(bus0.k1), 32'h0);

        // 5: enable dropped while ch0 sits in CLEAR
        cyc(4'b0001); cyc(4'b0000); cyc(4'b0001); cyc(4'b0000);
        check("t5_cnt_pre", 32'(bus0.seq_cnt[3:0]), 32'd1);
        cyc(4'b0001); cyc(4'b0000); cyc(4'b0001);
        check("t5_in_clear", 32'(bus0.state[1:0]), 32'd3);
        bus0.en = 1'b0;
        cyc(4'b0000);
        check("t5_off_state", 32'(bus0.state), 32'h00);
        check("t5_off_k1", 32'(bus0.k1), 32'h0);
        check("t5_off_cnt", 32'(bus0.seq_cnt[3:0]), 32'd1);
        bus0.en = 1'b1;
        cyc(4'b0001); cyc(4'b0000); cyc(4'b0001); cyc(4'b0000);
        check("t5_re_k1", 32'(bus0.k1), 32'h1);
        check("t5_re_cnt", 32'(bus0.seq_cnt[3:0]), 32'd2);

        // 6: reset with ch0 in STOP and ch1 in CLEAR
        cyc(4'b0010); cyc(4'b0001); cyc(4'b0010);
        check("t6_pre_state", 32'(bus0.state), 32'h0E);
        rst = 1'b1;
        cyc(4'b0001);
        check("t6_state", 32'(bus0.state), 32'h00);
        check("t6_pulses", {bus0.k1, bus0.k2, bus0.tmo}, 32'h0);
        check("t6_cnt", 32'(bus0.seq_cnt), 32'h0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
